// File: rtl/csh_wb_seq_if.sv
// Bus bundle for the cache write-back sequencer.
//   master modport : the sequencer itself (drives cache read and memory side)
//   slave modport  : the surrounding directory/control, cache RAM and memory bus
// Signals:
//   wb_req_h/wb_set_h/wb_way_h/wb_first_wd_h : line request and its operands
//   wb_busy_h, wb_done_h                    : sequencer status
//   cache_adr_h/csh_sel_l/cache_rd_en_l     : cache data RAM read port
//   cache_data_h/csh_par_bit_h              : read data + stored parity (1-cycle latency)
//   cache_to_mem_h/mem_wd_adr_h/mem_valid_h/mem_ack_h : memory-side word handshake
//   wb_par_err_h/wb_par_err_wd_h            : sticky parity status for the current line
//   wb_state_dbg                            : FSM state, observation only
//
// Memory handshake: a word moves when mem_valid_h and mem_ack_h are both high at a
// rising edge; while mem_valid_h is high and mem_ack_h low, cache_to_mem_h and
// mem_wd_adr_h hold their values; mem_ack_h is meaningless while mem_valid_h is low.
interface csh_wb_seq_if #(
    parameter int WD_BITS  = 36,
    parameter int SET_BITS = 7,
    parameter int WAYS     = 4
);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int ADR_BITS = SET_BITS + 2;

    logic                wb_req_h;
    logic [SET_BITS-1:0] wb_set_h;
    logic [WAY_BITS-1:0] wb_way_h;
    logic [1:0]          wb_first_wd_h;
    logic                wb_busy_h;
    logic [ADR_BITS-1:0] cache_adr_h;
    logic [WAYS-1:0]     csh_sel_l;
    logic                cache_rd_en_l;
    logic [WD_BITS-1:0]  cache_data_h;
    logic                csh_par_bit_h;
    logic [WD_BITS-1:0]  cache_to_mem_h;
    logic [ADR_BITS-1:0] mem_wd_adr_h;
    logic                mem_valid_h;
    logic                mem_ack_h;
    logic                wb_done_h;
    logic                wb_par_err_h;
    logic [1:0]          wb_par_err_wd_h;
    logic [2:0]          wb_state_dbg;

    modport master (
        input  wb_req_h, wb_set_h, wb_way_h, wb_first_wd_h,
        input  cache_data_h, csh_par_bit_h, mem_ack_h,
        output wb_busy_h, cache_adr_h, csh_sel_l, cache_rd_en_l,
        output cache_to_mem_h, mem_wd_adr_h, mem_valid_h,
        output wb_done_h, wb_par_err_h, wb_par_err_wd_h, wb_state_dbg
    );

    modport slave (
        output wb_req_h, wb_set_h, wb_way_h, wb_first_wd_h,
        output cache_data_h, csh_par_bit_h, mem_ack_h,
        input  wb_busy_h, cache_adr_h, csh_sel_l, cache_rd_en_l,
        input  cache_to_mem_h, mem_wd_adr_h, mem_valid_h,
        input  wb_done_h, wb_par_err_h, wb_par_err_wd_h, wb_state_dbg
    );
endinterface

// File: rtl/csh_wb_seq.sv
// Cache write-back sequencer: reads one 4-word line (wrap-around order from the
// requested first word) out of the cache data RAM, checks odd parity on every word,
// buffers the line and then hands the words to memory one per valid/ack handshake.
// Ports:
//   clk   : system clock, rising edge
//   rst_h : synchronous active-high reset
//   bus   : csh_wb_seq_if.master (request, cache read port, memory port, status)
module csh_wb_seq #(
    parameter int WD_BITS  = 36,
    parameter int SET_BITS = 7,
    parameter int WAYS     = 4
) (
    input  logic         clk,
    input  logic         rst_h,
    csh_wb_seq_if.master bus
);
    localparam int WAY_BITS = $clog2(WAYS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          k_q, k_d;          // read count within RD
    logic [1:0]          i_q, i_d;          // transfer index within XFER
    logic [SET_BITS-1:0] set_q, set_d;
    logic [WAY_BITS-1:0] way_q, way_d;
    logic [1:0]          first_q, first_d;
    logic                rd_vld_q, rd_vld_d; // a read was issued last cycle
    logic [1:0]          rd_idx_q, rd_idx_d; // buffer slot of that read
    logic                err_q, err_d;
    logic [1:0]          err_wd_q, err_wd_d;
    logic [WD_BITS-1:0]  buf_q [4];
    logic [WD_BITS-1:0]  buf_d [4];

    logic                par_bad;
    logic [1:0]          rd_wd;
    logic [1:0]          xfer_wd;

    // Odd parity over data plus stored bit; an even total marks a bad word.
    assign par_bad = ~(^{bus.cache_data_h, bus.csh_par_bit_h});
    assign rd_wd   = first_q + k_q;
    assign xfer_wd = first_q + i_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst_h) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            i_q      <= '0;
            set_q    <= '0;
            way_q    <= '0;
            first_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            err_q    <= 1'b0;
            err_wd_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            i_q      <= i_d;
            set_q    <= set_d;
            way_q    <= way_d;
            first_q  <= first_d;
            rd_vld_q <= rd_vld_d;
            rd_idx_q <= rd_idx_d;
            err_q    <= err_d;
            err_wd_q <= err_wd_d;
        end
    end

    // Line buffer contents are irrelevant after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.wb_req_h) state_d = S_RD;
            S_RD:   if (k_q == 2'd3) state_d = S_CAP;
            S_CAP:  state_d = S_XFER;
            S_XFER: if (bus.mem_ack_h && (i_q == 2'd3)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath register updates.
    always_comb begin
        k_d      = k_q;
        i_d      = i_q;
        set_d    = set_q;
        way_d    = way_q;
        first_d  = first_q;
        err_d    = err_q;
        err_wd_d = err_wd_q;
        buf_d    = buf_q;
        rd_vld_d = (state_q == S_RD);
        rd_idx_d = k_q;
        case (state_q)
            S_IDLE: begin
                if (bus.wb_req_h) begin
                    set_d    = bus.wb_set_h;
                    way_d    = bus.wb_way_h;
                    first_d  = bus.wb_first_wd_h;
                    k_d      = '0;
                    err_d    = 1'b0;
                    err_wd_d = '0;
                end
            end
            S_RD:   k_d = k_q + 2'd1;
            S_CAP:  i_d = '0;
            S_XFER: if (bus.mem_ack_h) i_d = i_q + 2'd1;
            default: ;
        endcase
        // Data returns one cycle after the read; this covers RD k=1..3 and CAP.
        if (rd_vld_q) begin
            buf_d[rd_idx_q] = bus.cache_data_h;
            if (par_bad && !err_q) begin
                err_d    = 1'b1;
                err_wd_d = first_q + rd_idx_q;
            end
        end
    end

    // Outputs, decoded from the registered state.
    always_comb begin
        bus.cache_adr_h    = '0;
        bus.csh_sel_l      = '1;
        bus.cache_rd_en_l  = 1'b1;
        bus.cache_to_mem_h = '0;
        bus.mem_wd_adr_h   = '0;
        bus.mem_valid_h    = 1'b0;
        bus.wb_done_h      = 1'b0;
        case (state_q)
            S_RD: begin
                bus.cache_adr_h       = {set_q, rd_wd};
                bus.csh_sel_l[way_q]  = 1'b0;
                bus.cache_rd_en_l     = 1'b0;
            end
            S_XFER: begin
                bus.mem_valid_h    = 1'b1;
                bus.cache_to_mem_h = buf_q[i_q];
                bus.mem_wd_adr_h   = {set_q, xfer_wd};
            end
            S_DONE: bus.wb_done_h = 1'b1;
            default: ;
        endcase
        bus.wb_busy_h       = (state_q != S_IDLE);
        bus.wb_par_err_h    = err_q;
        bus.wb_par_err_wd_h = err_wd_q;
        bus.wb_state_dbg    = state_q;
    end
endmodule

// File: tb/tb_csh_wb_seq.sv
// Directed bench for csh_wb_seq: a cache RAM model answers reads, a scoreboard holds
// the expected read addresses and the expected memory-side words/addresses.
module tb_csh_wb_seq;
    logic clk;
    logic rst_h;

    csh_wb_seq_if bus ();

    csh_wb_seq dut (
        .clk   (clk),
        .rst_h (rst_h),
        .bus   (bus.master)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [24:0] seed = '0;
    logic [3:0]  inject = '0;   // word addresses answered with bad parity
    int          xfer_cnt = 0;
    int          stall_cnt = 0;
    int          done_cnt = 0;

    logic [35:0] exp_q[$];
    logic [8:0]  exp_adr_q[$];
    logic [12:0] exp_rd_q[$];   // {csh_sel_l, cache_adr_h}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mem_word(input logic [6:0] s, input logic [1:0] wy,
                                             input logic [1:0] w);
        return {s, wy, w, seed} ^ 36'h5A5A5A5A5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [6:0] s, input logic [1:0] wy, input logic [1:0] f);
        logic [1:0] w;
        logic [3:0] sl;
        sl = 4'hF;
        sl[wy] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = f + 2'(k);
            exp_rd_q.push_back({sl, s, w});
            exp_q.push_back(mem_word(s, wy, w));
            exp_adr_q.push_back({s, w});
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns in the cycle after accept.
    task automatic do_req(input logic [6:0] s, input logic [1:0] wy, input logic [1:0] f,
                          input logic hold);
        seed = 25'($urandom);
        xfer_cnt = 0;
        stall_cnt = 0;
        done_cnt = 0;
        push_line(s, wy, f);
        bus.wb_set_h = s;
        bus.wb_way_h = wy;
        bus.wb_first_wd_h = f;
        bus.wb_req_h = 1'b1;
        @(negedge clk);
        check("busy_before_accept", 64'(bus.wb_busy_h), 64'd0);
        tick();
        if (!hold) bus.wb_req_h = 1'b0;
    endtask

    // n: negedges until wb_done_h seen; nv: negedge count of first mem_valid_h.
    task automatic wait_done(input int budget, output int n, output int nv);
        n = 0;
        nv = 0;
        do begin
            @(negedge clk);
            n++;
            if (nv == 0 && bus.mem_valid_h) nv = n;
        end while (!bus.wb_done_h && n < budget);
        check("done_seen", 64'(bus.wb_done_h), 64'd1);
    endtask

    task automatic check_reset();
        check("rst_busy", 64'(bus.wb_busy_h), 64'd0);
        check("rst_cache_adr", 64'(bus.cache_adr_h), 64'd0);
        check("rst_sel_l", 64'(bus.csh_sel_l), 64'hF);
        check("rst_rd_en_l", 64'(bus.cache_rd_en_l), 64'd1);
        check("rst_to_mem", 64'(bus.cache_to_mem_h), 64'd0);
        check("rst_mem_adr", 64'(bus.mem_wd_adr_h), 64'd0);
        check("rst_mem_valid", 64'(bus.mem_valid_h), 64'd0);
        check("rst_done", 64'(bus.wb_done_h), 64'd0);
        check("rst_par_err", 64'(bus.wb_par_err_h), 64'd0);
        check("rst_par_err_wd", 64'(bus.wb_par_err_wd_h), 64'd0);
    endtask

    // Cache RAM model: answers the read seen in one cycle during the next cycle.
    initial begin
        logic [35:0] pend_d;
        logic        pend_p;
        logic [1:0]  wy;
        int          nlow;
        bus.cache_data_h = '0;
        bus.csh_par_bit_h = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cache_rd_en_l === 1'b0) begin
                nlow = 0;
                wy = '0;
                for (int i = 0; i < 4; i++) begin
                    if (!bus.csh_sel_l[i]) begin
                        nlow++;
                        wy = 2'(i);
                    end
                end
                pend_d = (nlow == 1) ? mem_word(bus.cache_adr_h[8:2], wy, bus.cache_adr_h[1:0])
                                     : 36'h0;
                pend_p = inject[bus.cache_adr_h[1:0]] ? (^pend_d) : ~(^pend_d);
            end else begin
                pend_d = 36'($urandom);
                pend_p = 1'($urandom_range(0, 1));
            end
            tick();
            bus.cache_data_h = pend_d;
            bus.csh_par_bit_h = pend_p;
        end
    end

    // Scoreboard monitor
    initial begin
        logic        stall_prev;
        logic [35:0] prev_data;
        logic [8:0]  prev_adr;
        logic [12:0] e_rd;
        stall_prev = 1'b0;
        prev_data = '0;
        prev_adr = '0;
        forever begin
            @(negedge clk);
            if (rst_h !== 1'b0) begin
                stall_prev = 1'b0;
            end else begin
                if (!bus.cache_rd_en_l) begin
                    check("rd_expected", 64'(exp_rd_q.size() > 0), 64'd1);
                    if (exp_rd_q.size() > 0) begin
                        e_rd = exp_rd_q.pop_front();
                        check("rd_adr", 64'(bus.cache_adr_h), 64'(e_rd[8:0]));
                        check("rd_sel_l", 64'(bus.csh_sel_l), 64'(e_rd[12:9]));
                    end
                end
                if (stall_prev && bus.mem_valid_h) begin
                    check("stall_data_stable", 64'(bus.cache_to_mem_h), 64'(prev_data));
                    check("stall_adr_stable", 64'(bus.mem_wd_adr_h), 64'(prev_adr));
                end
                if (bus.mem_valid_h && bus.mem_ack_h) begin
                    xfer_cnt++;
                    check("xfer_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        check("xfer_data", 64'(bus.cache_to_mem_h), 64'(exp_q.pop_front()));
                        check("xfer_adr", 64'(bus.mem_wd_adr_h), 64'(exp_adr_q.pop_front()));
                    end
                end
                if (bus.mem_valid_h && !bus.mem_ack_h) stall_cnt++;
                stall_prev = bus.mem_valid_h && !bus.mem_ack_h;
                prev_data = bus.cache_to_mem_h;
                prev_adr = bus.mem_wd_adr_h;
                if (bus.wb_done_h) done_cnt++;
            end
        end
    end

    // Directed sequence
    initial begin
        int n;
        int nv;
        logic [6:0] s;
        logic [1:0] wy;
        rst_h = 1'b1;
        bus.wb_req_h = 1'b0;
        bus.wb_set_h = '0;
        bus.wb_way_h = '0;
        bus.wb_first_wd_h = '0;
        bus.mem_ack_h = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset();
        tick();
        rst_h = 1'b0;
        tick();

        // Basic line, ack tied high: first valid in cycle 7, done in cycle 11.
        bus.mem_ack_h = 1'b1;
        do_req(7'h15, 2'd2, 2'd0, 1'b0);
        wait_done(40, n, nv);
        check("t1_done_cycle", 64'(n + 1), 64'd11);
        check("t1_first_valid_cycle", 64'(nv + 1), 64'd7);
        check("t1_par_err", 64'(bus.wb_par_err_h), 64'd0);
        check("t1_xfer_cnt", 64'(xfer_cnt), 64'd4);
        @(negedge clk);
        check("t1_done_one_cycle", 64'(bus.wb_done_h), 64'd0);
        check("t1_idle_after", 64'(bus.wb_busy_h), 64'd0);
        tick();

        // Wrap-around from word 3, plus a stray request pulse while busy.
        wy = 2'($urandom_range(0, 3));
        do_req(7'h7F, wy, 2'd3, 1'b0);
        repeat (3) tick();
        bus.wb_set_h = 7'h11;
        bus.wb_req_h = 1'b1;
        tick();
        bus.wb_req_h = 1'b0;
        wait_done(40, n, nv);
        check("t2_xfer_cnt", 64'(xfer_cnt), 64'd4);
        tick();

        // Ack stalls: ack during CAP, 5 stalled cycles on word index 1.
        bus.mem_ack_h = 1'b0;
        s = 7'($urandom_range(0, 127));
        do_req(s, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
        repeat (4) tick();
        bus.mem_ack_h = 1'b1;
        tick();
        tick();
        bus.mem_ack_h = 1'b0;
        repeat (5) tick();
        bus.mem_ack_h = 1'b1;
        wait_done(40, n, nv);
        check("t3_stall_cnt", 64'(stall_cnt), 64'd5);
        check("t3_xfer_cnt", 64'(xfer_cnt), 64'd4);
        tick();

        // Parity errors on words 2 and 3, line starting at word 1.
        inject = 4'b1100;
        do_req(7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)), 2'd1, 1'b0);
        wait_done(40, n, nv);
        check("t4_par_err", 64'(bus.wb_par_err_h), 64'd1);
        check("t4_par_err_wd", 64'(bus.wb_par_err_wd_h), 64'd2);
        check("t4_xfer_cnt", 64'(xfer_cnt), 64'd4);
        tick();
        inject = 4'b0000;
        do_req(7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)), 2'd2, 1'b0);
        @(negedge clk);
        check("t4_err_cleared", 64'(bus.wb_par_err_h), 64'd0);
        check("t4_err_wd_cleared", 64'(bus.wb_par_err_wd_h), 64'd0);
        wait_done(40, n, nv);
        check("t4_clean_par_err", 64'(bus.wb_par_err_h), 64'd0);
        tick();

        // Reset during XFER after two acks, with ack still high.
        do_req(7'h2A, 2'd1, 2'd0, 1'b0);
        n = 0;
        while (xfer_cnt < 2 && n < 50) begin
            tick();
            n++;
        end
        check("t5_two_acks", 64'(xfer_cnt), 64'd2);
        rst_h = 1'b1;
        tick();
        rst_h = 1'b0;
        exp_q.delete();
        exp_adr_q.delete();
        exp_rd_q.delete();
        @(negedge clk);
        check_reset();
        tick();
        do_req(7'h2A, 2'd1, 2'd0, 1'b0);
        wait_done(40, n, nv);
        check("t5_xfer_cnt", 64'(xfer_cnt), 64'd4);
        tick();

        // Request held high: back-to-back lines separated by one IDLE cycle.
        s = 7'($urandom_range(0, 127));
        wy = 2'($urandom_range(0, 3));
        do_req(s, wy, 2'd1, 1'b1);
        push_line(s, wy, 2'd1);
        wait_done(40, n, nv);
        check("t6_first_done", 64'(n), 64'd10);
        @(negedge clk);
        check("t6_idle_gap", 64'(bus.wb_busy_h), 64'd0);
        @(negedge clk);
        check("t6_second_busy", 64'(bus.wb_busy_h), 64'd1);
        wait_done(40, n, nv);
        check("t6_second_done", 64'(n), 64'd9);
        tick();
        bus.wb_req_h = 1'b0;
        repeat (15) tick();
        @(negedge clk);
        check("t6_idle_end", 64'(bus.wb_busy_h), 64'd0);
        check("t6_done_cnt", 64'(done_cnt), 64'd2);
        check("t6_xfer_cnt", 64'(xfer_cnt), 64'd8);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("exp_rd_q_drained", 64'(exp_rd_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/csh_wb_seq.md
Name: csh_wb_seq

Overview:
- Cache write-back sequencer. It is the read-out counterpart of the cache data RAM fill path.
- On request, it reads one 4-word cache line from a selected set and way over the cache data bus, checking odd parity on each word.
- It buffers the four words, then ships them one at a time to the memory side using a valid/ack handshake.
- It sits between the cache directory/control logic and the memory bus interface.

Parameters:
- WD_BITS, 36: data word width.
- SET_BITS, 7: set index width (cache address bits 27..33).
- WAYS, 4: number of ways; one active-low select per way.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_h  in  1  synchronous, active-high reset.
- wb_req_h  in  1  write-back request; sampled only in IDLE.
- wb_set_h  in  7  line set index; captured on accept.
- wb_way_h  in  2  way to read; captured on accept.
- wb_first_wd_h  in  2  first word of the line to transfer; captured on accept.
- wb_busy_h  out  1  high from the cycle after accept until DONE exits.
- cache_adr_h  out  9  cache word address {set, word} (bits 27..35).
- csh_sel_l  out  4  active-low way select; one bit low while reading.
- cache_rd_en_l  out  1  active-low cache data output enable.
- cache_data_h  in  36  cache read data; valid one cycle after address/enable.
- csh_par_bit_h  in  1  stored parity bit; arrives with cache_data_h.
- cache_to_mem_h  out  36  word presented to memory.
- mem_wd_adr_h  out  9  {set, word} of the presented word.
- mem_valid_h  out  1  word valid to memory.
- mem_ack_h  in  1  memory accepted the presented word.
- wb_done_h  out  1  one-cycle pulse when the line is complete.
- wb_par_err_h  out  1  sticky parity error flag for the current line.
- wb_par_err_wd_h  out  2  word address of the first bad word.

Behaviour:
- Reset values (rst_h high):
  - State IDLE; wb_busy_h=0.
  - cache_adr_h=0, csh_sel_l=4'hF, cache_rd_en_l=1.
  - cache_to_mem_h=0, mem_wd_adr_h=0, mem_valid_h=0.
  - wb_done_h=0, wb_par_err_h=0, wb_par_err_wd_h=0.
- Reset takes priority over every other event, mid-operation included. The buffer contents are don't-care after reset.
- States: IDLE -> RD -> CAP -> XFER -> DONE -> IDLE.
- IDLE:
  - wb_req_h=1 accepts the request and captures set, way and first word.
  - Accept clears wb_par_err_h and wb_par_err_wd_h.
  - Next state is RD with read count k=0.
- RD (4 cycles, k=0..3):
  - Drive cache_adr_h = {set, (first+k) mod 4} and cache_rd_en_l=0.
  - csh_sel_l has bit [way] low and all other bits high.
  - The word returned one cycle later is captured into buf[k].
  - After k=3, go to CAP.
- CAP (1 cycle):
  - Address, select and enable return to idle values.
  - The k=3 data is captured.
  - Go to XFER with transfer index i=0.
- Parity check on every capture:
  - Odd parity: error when XOR(data[35:0], par) == 0.
  - On the first error of a line, set wb_par_err_h=1 and wb_par_err_wd_h = word address of that word.
  - Later errors do not change wb_par_err_wd_h.
  - A parity error does not abort the line.
- XFER:
  - mem_valid_h=1, cache_to_mem_h=buf[i], mem_wd_adr_h = {set, (first+i) mod 4}.
  - Data and address stay stable while ack is low.
  - On mem_ack_h=1, i increments. The next word is valid in the following cycle, so valid stays high back-to-back.
  - The ack for i=3 moves to DONE, and mem_valid_h drops in that same edge.
- DONE: wb_done_h=1 for exactly 1 cycle, then IDLE.
- Word order is wrap-around: first=2 yields 2,3,0,1.
- mem_ack_h is ignored when mem_valid_h=0.
- wb_req_h is ignored outside IDLE and is not queued. A request held high through DONE is accepted in the following IDLE cycle.
- Minimum latency from accept to the first mem_valid_h is 6 cycles (accept, RD×4, CAP). The line completes in a minimum of 11 cycles with immediate acks.

Test Plan:
- Reset, then request set=7'h15, way=2, first=0, with ack tied high:
  - cache_adr_h steps 0x054..0x057 with csh_sel_l=4'b1011.
  - mem receives buf words in order with mem_wd_adr_h 0x054..0x057.
  - wb_done_h pulses in cycle 11.
  - wb_par_err_h=0.
- first=3, set=7'h7F:
  - Read and transfer order is words 3,0,1,2.
  - Addresses are 0x1FF, 0x1FC, 0x1FD, 0x1FE.
- Ack stalls: hold mem_ack_h low for 5 cycles on i=1, and pulse ack during CAP.
  - cache_to_mem_h and mem_wd_adr_h stay stable while stalled.
  - The CAP ack has no effect.
  - Exactly 4 words are transferred.
- Parity errors: inject even parity on word address 2, then on word address 3, with first=1.
  - wb_par_err_h=1 and wb_par_err_wd_h=2.
  - All 4 words are still sent.
  - A new accepted request clears the flag.
- Reset during XFER after 2 acks:
  - Next cycle shows all reset values.
  - A new request restarts from RD and sends 4 fresh words.
  - Asserting mem_ack_h together with rst_h still yields reset.
- Request held high continuously:
  - Pulses asserted during busy are ignored.
  - A second line starts only in the IDLE cycle following DONE.
  - wb_done_h pulses once per line.
